// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates the single-port unified memory between the fetch stage
// (instruction reads) and the memory stage (data reads/writes). One requester
// is granted at a time, with fixed priority: the memory stage beats fetch
// because it holds the older instruction. The granted request's address,
// write enable and write data are captured on grant, so the memory sees a
// stable request for the whole transaction. Every transaction has a bounded
// wait. On timeout it is aborted and a sticky bus error is raised.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   if_req/if_addr       fetch read request (held until if_done)
//   if_done/if_rdata     fetch completion strobe and read data
//   ms_req/ms_we/...     memory-stage request (held until ms_done)
//   ms_done/ms_rdata     memory-stage completion strobe and read data
//   mem_*                memory handshake (mem_req held until mem_ready)
//   stall_fetch          fetch has a pending, not-yet-completed request
//   stall_mem            memory stage has a pending, not-yet-completed request
//   bus_error            sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // memory-stage requester
    input  logic              ms_req,
    input  logic              ms_we,
    input  logic [ADDR_W-1:0] ms_addr,
    input  logic [DATA_W-1:0] ms_wdata,
    output logic              ms_done,
    output logic [DATA_W-1:0] ms_rdata,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    // hazard / status
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              bus_error
);

    // Counter must be able to hold TIMEOUT-1 (the last value before abort).
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        MS_BUSY = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              we_q,        we_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              bus_error_q, bus_error_d;

    logic grant_ms;
    logic grant_if;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        bus_error_d = bus_error_q;
        grant_ms    = 1'b0;
        grant_if    = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here: no transaction is outstanding.
                if (ms_req) begin
                    grant_ms = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
            end

            IF_BUSY: begin
                if (mem_ready) begin
                    // The completing requester is never re-granted at this edge.
                    if (ms_req) begin
                        grant_ms = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            MS_BUSY: begin
                if (mem_ready) begin
                    if (if_req) begin
                        grant_if = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture the granted request so the memory sees stable inputs even
        // if the requester changes its address/data lines mid-transaction.
        if (grant_ms) begin
            state_d = MS_BUSY;
            cnt_d   = '0;
            addr_d  = ms_addr;
            we_d    = ms_we;
            wdata_d = ms_wdata;
        end else if (grant_if) begin
            state_d = IF_BUSY;
            cnt_d   = '0;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == MS_BUSY) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_done   = (state_q == IF_BUSY) & mem_ready;
    assign ms_done   = (state_q == MS_BUSY) & mem_ready;
    assign if_rdata  = mem_rdata;
    assign ms_rdata  = mem_rdata;

    assign stall_fetch = if_req & ~if_done;
    assign stall_mem   = ms_req & ~ms_done;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (who owns the port, how long it has waited, what it asked
// for) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    localparam int OWN_NONE = 0;
    localparam int OWN_IF   = 1;
    localparam int OWN_MS   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              ms_req;
    logic              ms_we;
    logic [ADDR_W-1:0] ms_addr;
    logic [DATA_W-1:0] ms_wdata;
    logic              ms_done;
    logic [DATA_W-1:0] ms_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_fetch;
    logic              stall_mem;
    logic              bus_error;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .ms_req     (ms_req),
        .ms_we      (ms_we),
        .ms_addr    (ms_addr),
        .ms_wdata   (ms_wdata),
        .ms_done    (ms_done),
        .ms_rdata   (ms_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stall_fetch(stall_fetch),
        .stall_mem  (stall_mem),
        .bus_error  (bus_error)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the port owner, cycles waited so far, and the request
    // captured when the owner was granted.
    int                m_owner = OWN_NONE;
    int                m_wait  = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic              m_we    = 1'b0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic              m_berr  = 1'b0;

    // Completions predicted in the most recent step (used by the random driver).
    logic last_if_done = 1'b0;
    logic last_ms_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        m_wait  = 0;
        if (who == OWN_MS) begin
            m_addr  = ms_addr;
            m_we    = ms_we;
            m_wdata = ms_wdata;
        end else begin
            m_addr  = if_addr;
            m_we    = 1'b0;
            m_wdata = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        int other;
        if (!rst_n) begin
            m_owner = OWN_NONE;
            m_wait  = 0;
            m_addr  = '0;
            m_we    = 1'b0;
            m_wdata = '0;
            m_berr  = 1'b0;
        end else if (m_owner == OWN_NONE) begin
            if (ms_req)      model_grant(OWN_MS);
            else if (if_req) model_grant(OWN_IF);
        end else if (mem_ready) begin
            other = (m_owner == OWN_MS) ? OWN_IF : OWN_MS;
            if ((other == OWN_MS && ms_req) || (other == OWN_IF && if_req))
                model_grant(other);
            else
                m_owner = OWN_NONE;
        end else if (m_wait + 1 == TIMEOUT) begin
            m_owner = OWN_NONE;
            m_berr  = 1'b1;
        end else begin
            m_wait++;
        end
    endtask

    // One clock cycle: compare all outputs mid-cycle, then step the model at
    // the rising edge; returns just after the edge so the caller can drive.
    task automatic step();
        logic e_if_done, e_ms_done;
        @(negedge clk);
        e_if_done = (m_owner == OWN_IF) && mem_ready;
        e_ms_done = (m_owner == OWN_MS) && mem_ready;
        check("mem_req",     32'(mem_req),     32'(m_owner != OWN_NONE));
        check("mem_we",      32'(mem_we),      32'((m_owner == OWN_MS) && m_we));
        check("mem_addr",    32'(mem_addr),    32'(m_addr));
        check("mem_wdata",   32'(mem_wdata),   32'(m_wdata));
        check("if_done",     32'(if_done),     32'(e_if_done));
        check("ms_done",     32'(ms_done),     32'(e_ms_done));
        check("stall_fetch", 32'(stall_fetch), 32'(if_req && !e_if_done));
        check("stall_mem",   32'(stall_mem),   32'(ms_req && !e_ms_done));
        check("bus_error",   32'(bus_error),   32'(m_berr));
        if (e_if_done) check("if_rdata", 32'(if_rdata), 32'(mem_rdata));
        if (e_ms_done) check("ms_rdata", 32'(ms_rdata), 32'(mem_rdata));
        last_if_done = e_if_done;
        last_ms_done = e_ms_done;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int n;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        ms_req    = 1'b0;
        ms_we     = 1'b0;
        ms_addr   = '0;
        ms_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset, then idle with no requests.
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_mem_req", 32'(mem_req), 32'd0);

        // Single fetch, ready on the first busy cycle.
        if_req  = 1'b1;
        if_addr = 16'h0010;
        #1 check("fetch_stall_pending", 32'(stall_fetch), 32'd1);
        step();
        mem_ready = 1'b1;
        mem_rdata = 16'hABCD;
        #1;
        check("fetch_mem_addr", 32'(mem_addr), 32'h0010);
        check("fetch_if_done",  32'(if_done),  32'd1);
        check("fetch_if_rdata", 32'(if_rdata), 32'hABCD);
        check("fetch_stall_lo", 32'(stall_fetch), 32'd0);
        step();
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // Contention: MS wins, then IF follows with no idle cycle.
        if_req   = 1'b1;
        if_addr  = 16'h0020;
        ms_req   = 1'b1;
        ms_we    = 1'b1;
        ms_addr  = 16'h0200;
        ms_wdata = 16'h1234;
        step();
        #1;
        check("cont_mem_we",    32'(mem_we),      32'd1);
        check("cont_mem_wdata", 32'(mem_wdata),   32'h1234);
        check("cont_mem_addr",  32'(mem_addr),    32'h0200);
        check("cont_stall_if",  32'(stall_fetch), 32'd1);
        mem_ready = 1'b1;
        step();
        ms_req = 1'b0;
        ms_we  = 1'b0;
        #1;
        check("cont_if_req",  32'(mem_req),  32'd1);
        check("cont_if_addr", 32'(mem_addr), 32'h0020);
        check("cont_if_we",   32'(mem_we),   32'd0);
        step();
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // Wait states: ready in the 3rd busy cycle, ms_addr toggling meanwhile.
        ms_req  = 1'b1;
        ms_we   = 1'b0;
        ms_addr = 16'h0300;
        step();
        for (int i = 0; i < 2; i++) begin
            ms_addr = 16'($urandom);
            ms_we   = 1'b1;
            #1 check("ws_addr_stable", 32'(mem_addr), 32'h0300);
            check("ws_no_done", 32'(ms_done), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        #1 check("ws_done", 32'(ms_done), 32'd1);
        check("ws_we_stable", 32'(mem_we), 32'd0);
        step();
        ms_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // Timeout: memory never readies.
        ms_req   = 1'b1;
        ms_we    = 1'b1;
        ms_addr  = 16'h0400;
        ms_wdata = 16'h5555;
        step();
        n = 0;
        while (mem_req === 1'b1 && n < 3 * TIMEOUT) begin
            n++;
            step();
        end
        check("to_busy_cycles", 32'(n), 32'(TIMEOUT));
        check("to_bus_error",   32'(bus_error), 32'd1);
        check("to_stall_mem",   32'(stall_mem), 32'd1);
        step();
        check("to_regrant", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        step();
        ms_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        check("to_sticky", 32'(bus_error), 32'd1);

        // Reset mid-transaction, then a late ready.
        ms_req  = 1'b1;
        ms_we   = 1'b0;
        ms_addr = 16'h0500;
        step();
        rst_n = 1'b0;
        step();
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        rst_n     = 1'b1;
        ms_req    = 1'b0;
        mem_ready = 1'b1;
        #1 check("rst_late_ready", 32'(ms_done), 32'd0);
        step();
        mem_ready = 1'b0;
        step();

        // Randomized traffic: requesters hold until done, random memory waits,
        // occasional long not-ready windows and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if (!if_req || last_if_done) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 16'($urandom);
            end
            if (!ms_req || last_ms_done) begin
                ms_req = ($urandom_range(0, 2) == 0);
            end
            ms_we     = 1'($urandom);
            ms_addr   = 16'($urandom);
            ms_wdata  = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_ready = ((i % 500) < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
